i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_pkg.sv | 17 +
 rtl/i2s_shift.sv | 22 ++
 rtl/i2s_rx.sv | 134 +++++++++++++
 tb/tb_i2s_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// rtl/i2s_rx_pkg.sv - shared I2S slot constants and capture state type
package i2s_rx_pkg;

   localparam int FRAME_SLOTS = 64;
   localparam int SLOT_W      = $clog2(FRAME_SLOTS);

   localparam logic [SLOT_W-1:0] SLOT_LEFT_START  = SLOT_W'(1);
   localparam logic [SLOT_W-1:0] SLOT_RIGHT_START = SLOT_W'(33);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LEFT,
      ST_GAP,
      ST_RIGHT
   } cap_state_t;

endpackage

// File: rtl/i2s_shift.sv
// rtl/i2s_shift.sv - MSB-first serial-in shift register with clear and shift-enable
module i2s_shift #(
   parameter int BITS = 24
) (
   input  logic            ck,
   input  logic            rst,
   input  logic            clr,
   input  logic            shift,
   input  logic            d,
   output logic [BITS-1:0] q
);

   // Shift-and-or form keeps BITS=1 legal without a zero-width slice.
   always_ff @(posedge ck) begin
      if (rst || clr) begin
         q <= '0;
      end else if (shift) begin
         q <= (q << 1) | BITS'(d);
      end
   end

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S stereo receiver: slot-tracked capture with a one-deep output holding register
module i2s_rx
   import i2s_rx_pkg::*;
#(
   parameter int BITS = 24
) (
   input  logic              ck,
   input  logic              rst,
   input  logic              en,
   input  logic [SLOT_W-1:0] frame_posn,
   input  logic              sd,
   output logic [BITS-1:0]   left,
   output logic [BITS-1:0]   right,
   output logic              valid,
   input  logic              ready,
   output logic              overflow,
   output logic [7:0]        drops
);

   localparam logic [SLOT_W-1:0] LEFT_LAST  = SLOT_W'(int'(SLOT_LEFT_START) + BITS - 1);
   localparam logic [SLOT_W-1:0] RIGHT_LAST = SLOT_W'(int'(SLOT_RIGHT_START) + BITS - 1);

   logic              sd_s1, sd_s2;
   logic              en_d1, en_d2;
   logic [SLOT_W-1:0] posn_d1, posn_d2;

   cap_state_t        state;
   logic [SLOT_W-1:0] exp_slot;

   logic              sof, in_seq, slip, clr;
   logic              shift_l, shift_r, complete;
   logic [BITS-1:0]   l_q, r_q, r_next;

   // en/frame_posn ride two stages so each strobe meets the sd bit it framed.
   always_ff @(posedge ck) begin
      if (rst) begin
         sd_s1   <= 1'b0;
         sd_s2   <= 1'b0;
         en_d1   <= 1'b0;
         en_d2   <= 1'b0;
         posn_d1 <= '0;
         posn_d2 <= '0;
      end else begin
         sd_s1   <= sd;
         sd_s2   <= sd_s1;
         en_d1   <= en;
         en_d2   <= en_d1;
         posn_d1 <= frame_posn;
         posn_d2 <= posn_d1;
      end
   end

   always_comb begin
      sof      = en_d2 && (posn_d2 == '0);
      in_seq   = (posn_d2 == exp_slot);
      slip     = en_d2 && (state != ST_IDLE) && !sof && !in_seq;
      clr      = sof || slip;
      shift_l  = en_d2 && (state == ST_LEFT) && in_seq &&
                 (posn_d2 >= SLOT_LEFT_START) && (posn_d2 <= LEFT_LAST);
      shift_r  = en_d2 && ((state == ST_GAP) || (state == ST_RIGHT)) && in_seq &&
                 (posn_d2 >= SLOT_RIGHT_START) && (posn_d2 <= RIGHT_LAST);
      complete = shift_r && (posn_d2 == RIGHT_LAST);
      r_next   = (r_q << 1) | BITS'(sd_s2);
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         state    <= ST_IDLE;
         exp_slot <= '0;
      end else if (en_d2) begin
         exp_slot <= posn_d2 + SLOT_W'(1);
         if (sof) begin
            state <= ST_LEFT;
         end else begin
            unique case (state)
               ST_IDLE: state <= ST_IDLE;
               ST_LEFT: begin
                  if (!in_seq)                    state <= ST_IDLE;
                  else if (posn_d2 == LEFT_LAST)  state <= ST_GAP;
               end
               ST_GAP: begin
                  if (!in_seq)                           state <= ST_IDLE;
                  else if (posn_d2 == SLOT_RIGHT_START)  state <= complete ? ST_IDLE : ST_RIGHT;
               end
               ST_RIGHT: begin
                  if (!in_seq || complete) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   i2s_shift #(.BITS(BITS)) u_shift_left (
      .ck    (ck),
      .rst   (rst),
      .clr   (clr),
      .shift (shift_l),
      .d     (sd_s2),
      .q     (l_q)
   );

   i2s_shift #(.BITS(BITS)) u_shift_right (
      .ck    (ck),
      .rst   (rst),
      .clr   (clr),
      .shift (shift_r),
      .d     (sd_s2),
      .q     (r_q)
   );

   // The last right bit is folded in directly so the pair lands on the completing edge.
   always_ff @(posedge ck) begin
      if (rst) begin
         left     <= '0;
         right    <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
         drops    <= '0;
      end else if (complete) begin
         if (!valid || ready) begin
            left  <= l_q;
            right <= r_next;
            valid <= 1'b1;
         end else begin
            overflow <= 1'b1;
            if (drops != 8'hFF) drops <= drops + 8'd1;
         end
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - scoreboard bench for i2s_rx
module tb_i2s_rx;
   import i2s_rx_pkg::*;

   localparam int BITS    = 24;
   localparam int R_LAST  = 32 + BITS;

   logic              ck = 1'b0;
   logic              rst, en, sd, ready;
   logic [SLOT_W-1:0] frame_posn;
   logic [BITS-1:0]   left, right;
   logic              valid, overflow;
   logic [7:0]        drops;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_slot_cyc = 0;

   logic [2*BITS-1:0] sb[$];
   logic              pv = 1'b0;
   logic              pr = 1'b0;

   i2s_rx #(.BITS(BITS)) dut (
      .ck         (ck),
      .rst        (rst),
      .en         (en),
      .frame_posn (frame_posn),
      .sd         (sd),
      .left       (left),
      .right      (right),
      .valid      (valid),
      .ready      (ready),
      .overflow   (overflow),
      .drops      (drops)
   );

   always #5 ck = ~ck;
   always @(posedge ck) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   function automatic logic slot_bit(input logic [BITS-1:0] l, input logic [BITS-1:0] r, input int s);
      if (s >= 1 && s <= BITS)        return l[BITS - s];
      if (s >= 33 && s <= 32 + BITS)  return r[32 + BITS - s];
      return logic'($urandom_range(1, 0));
   endfunction

   // Drives slots [start, stop) with one strobe every `spacing` ck; optionally
   // raises ready for the single cycle in which the pair completes.
   task automatic send_frame(input logic [BITS-1:0] l, input logic [BITS-1:0] r,
                             input int start, input int stop, input int spacing, input bit pulse);
      for (int s = start; s < stop; s++) begin
         for (int k = 0; k < spacing; k++) begin
            tick();
            if (k == 0) begin
               en         = 1'b1;
               frame_posn = SLOT_W'(s);
               sd         = slot_bit(l, r, s);
               if (s == R_LAST) last_slot_cyc = cyc;
            end else begin
               en = 1'b0;
            end
            if (pulse && s == R_LAST && k == 2) ready = 1'b1;
            if (pulse && s == R_LAST && k == 3) ready = 1'b0;
         end
      end
      tick();
      en = 1'b0;
   endtask

   // A fresh pair is visible when valid is high and the previous cycle either
   // had no pair or handed it off.
   always @(negedge ck) begin
      logic [2*BITS-1:0] want;
      if (!rst && valid && (!pv || pr)) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            want = sb.pop_front();
            chk("pair_left",  64'(left),  64'(want[2*BITS-1:BITS]));
            chk("pair_right", 64'(right), 64'(want[BITS-1:0]));
            chk("pair_latency", 64'(cyc - last_slot_cyc), 64'd3);
         end
      end
      pv = valid;
      pr = ready;
   end

   initial begin
      logic [BITS-1:0] l0, r0;
      rst = 1'b1; en = 1'b0; sd = 1'b0; ready = 1'b0; frame_posn = '0;
      repeat (4) tick();
      rst = 1'b0;
      @(negedge ck);
      chk("rst_left",     64'(left),     64'd0);
      chk("rst_right",    64'(right),    64'd0);
      chk("rst_valid",    64'(valid),    64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_drops",    64'(drops),    64'd0);

      // Basic capture with ready held high
      ready = 1'b1;
      sb.push_back({24'h123456, 24'hABCDEF});
      send_frame(24'h123456, 24'hABCDEF, 0, FRAME_SLOTS, 8, 1'b0);
      @(negedge ck);
      chk("basic_valid_cleared", 64'(valid), 64'd0);
      chk("basic_drops", 64'(drops), 64'd0);

      // Three frames with no consumer: first pair held, two dropped
      ready = 1'b0;
      sb.push_back({24'h0F0F0F, 24'hF0F0F0});
      send_frame(24'h0F0F0F, 24'hF0F0F0, 0, FRAME_SLOTS, 8, 1'b0);
      send_frame(24'h111111, 24'h222222, 0, FRAME_SLOTS, 8, 1'b0);
      send_frame(24'h333333, 24'h444444, 0, FRAME_SLOTS, 8, 1'b0);
      @(negedge ck);
      chk("hold_valid",    64'(valid),    64'd1);
      chk("hold_left",     64'(left),     64'h0F0F0F);
      chk("hold_right",    64'(right),    64'hF0F0F0);
      chk("hold_overflow", 64'(overflow), 64'd1);
      chk("hold_drops",    64'(drops),    64'd2);
      tick(); ready = 1'b1;
      tick(); tick(); ready = 1'b0;
      @(negedge ck);
      chk("consume_valid", 64'(valid), 64'd0);
      chk("consume_left_held", 64'(left), 64'h0F0F0F);

      // Completion coinciding with a handoff replaces the pair without a drop
      sb.push_back({24'h00AA55, 24'h7FFFFF});
      send_frame(24'h00AA55, 24'h7FFFFF, 0, FRAME_SLOTS, 8, 1'b0);
      sb.push_back({24'h800001, 24'h5A5A5A});
      send_frame(24'h800001, 24'h5A5A5A, 0, FRAME_SLOTS, 8, 1'b1);
      @(negedge ck);
      chk("swap_valid", 64'(valid), 64'd1);
      chk("swap_left",  64'(left),  64'h800001);
      chk("swap_drops", 64'(drops), 64'd2);
      tick(); ready = 1'b1;

      // Slot 0 injected at slot 40 restarts capture
      l0 = 24'hDEAD01; r0 = 24'hBEEF02;
      send_frame(24'h999999, 24'h888888, 0, 40, 8, 1'b0);
      sb.push_back({l0, r0});
      send_frame(l0, r0, 0, FRAME_SLOTS, 8, 1'b0);
      @(negedge ck);
      chk("resync_drops", 64'(drops), 64'd2);

      // Reset mid-frame
      send_frame(24'h777777, 24'h666666, 0, 10, 8, 1'b0);
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      @(negedge ck);
      chk("midrst_left",     64'(left),     64'd0);
      chk("midrst_right",    64'(right),    64'd0);
      chk("midrst_valid",    64'(valid),    64'd0);
      chk("midrst_overflow", 64'(overflow), 64'd0);
      chk("midrst_drops",    64'(drops),    64'd0);
      send_frame(24'h777777, 24'h666666, 10, FRAME_SLOTS, 8, 1'b0);
      sb.push_back({24'h13579B, 24'h2468AC});
      send_frame(24'h13579B, 24'h2468AC, 0, FRAME_SLOTS, 8, 1'b0);
      @(negedge ck);
      chk("postrst_sb_empty", 64'(sb.size()), 64'd0);

      // 300 drops saturate the counter
      ready = 1'b0;
      sb.push_back({24'hC0FFEE, 24'h0BADF0});
      send_frame(24'hC0FFEE, 24'h0BADF0, 0, FRAME_SLOTS, 1, 1'b0);
      for (int f = 0; f < 300; f++) begin
         send_frame(BITS'($urandom), BITS'($urandom), 0, FRAME_SLOTS, 1, 1'b0);
         if (f == 254) begin
            @(negedge ck);
            chk("sat_drops_255", 64'(drops), 64'd255);
         end
      end
      @(negedge ck);
      chk("sat_drops",    64'(drops),    64'd255);
      chk("sat_overflow", 64'(overflow), 64'd1);
      chk("sat_left",     64'(left),     64'hC0FFEE);
      chk("sat_right",    64'(right),    64'h0BADF0);
      tick(); ready = 1'b1;
      tick(); tick();
      @(negedge ck);
      chk("sat_consumed", 64'(valid), 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
